row_ptr_sequencer: RTL and testbench

ROW_PTR_SEQUENCER -- requirements
Module: row_ptr_sequencer

---
 rtl/row_ptr_sequencer.sv | 134 +++++++++++++
 tb/tb_row_ptr_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/row_ptr_sequencer.sv
// Row pointer sequencer: steps a row pointer up or down through a frame of L rows,
// counting completed frames and ending the run after a programmed frame count.
module row_ptr_sequencer #(
    parameter int unsigned NUM_ROWS   = 8,
    parameter int unsigned PTR_BITS   = $clog2(NUM_ROWS),
    parameter int unsigned FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  advance,
    input  logic                  dir,
    input  logic [PTR_BITS:0]     active_rows,
    input  logic [FRAME_BITS-1:0] num_frames,
    input  logic                  load,
    input  logic [PTR_BITS-1:0]   load_ptr,
    output logic [PTR_BITS-1:0]   row_ptr,
    output logic                  busy,
    output logic                  row_first,
    output logic                  row_last,
    output logic                  wrap,
    output logic                  done,
    output logic [FRAME_BITS-1:0] frame_cnt
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [PTR_BITS:0] MaxRows = (PTR_BITS + 1)'(NUM_ROWS);

    state_e                  state_q, state_d;
    logic [PTR_BITS-1:0]     ptr_q, ptr_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [FRAME_BITS-1:0]   nf_q, nf_d;
    logic [PTR_BITS:0]       limit_q, limit_d;
    logic                    dir_q, dir_d;
    logic                    wrap_q, wrap_d;
    logic                    done_q, done_d;

    logic [PTR_BITS:0]       limit_start;
    logic [PTR_BITS-1:0]     last_start;
    logic [PTR_BITS-1:0]     last_q;
    logic [PTR_BITS-1:0]     load_clamped;
    logic [FRAME_BITS-1:0]   frame_inc;
    logic                    at_end;

    // Out-of-range row counts (zero or above NUM_ROWS) fall back to the full array.
    assign limit_start  = (active_rows != '0 && active_rows <= MaxRows) ? active_rows : MaxRows;
    assign last_start   = PTR_BITS'(limit_start - 1'b1);
    assign last_q       = PTR_BITS'(limit_q - 1'b1);
    assign load_clamped = ({1'b0, load_ptr} >= limit_q) ? last_q : load_ptr;
    assign frame_inc    = frame_q + 1'b1;
    assign at_end       = dir_q ? (ptr_q == '0) : (ptr_q == last_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            frame_q <= '0;
            nf_q    <= '0;
            limit_q <= MaxRows;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            frame_q <= frame_d;
            nf_q    <= nf_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        frame_d = frame_q;
        nf_d    = nf_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    limit_d = limit_start;
                    dir_d   = dir;
                    nf_d    = num_frames;
                    frame_d = '0;
                    ptr_d   = dir ? last_start : '0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    ptr_d   = '0;
                end else if (load) begin
                    ptr_d = load_clamped;
                end else if (advance) begin
                    if (at_end) begin
                        wrap_d  = 1'b1;
                        frame_d = frame_inc;
                        if (nf_q != '0 && frame_inc == nf_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            ptr_d   = '0;
                        end else begin
                            ptr_d = dir_q ? last_q : '0;
                        end
                    end else begin
                        ptr_d = dir_q ? ptr_q - 1'b1 : ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StRun);
        row_ptr   = ptr_q;
        wrap      = wrap_q;
        done      = done_q;
        frame_cnt = frame_q;
        row_first = busy && (dir_q ? (ptr_q == last_q) : (ptr_q == '0));
        row_last  = busy && (dir_q ? (ptr_q == '0) : (ptr_q == last_q));
    end

endmodule

// File: tb/tb_row_ptr_sequencer.sv
// Bench for row_ptr_sequencer: directed scenarios then random traffic, all checked
// every cycle against an arithmetic model of the sequencer's behaviour.
module tb_row_ptr_sequencer;

    localparam int NR = 6;
    localparam int FB = 4;
    localparam int PB = $clog2(NR);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          advance = 1'b0;
    logic          dir = 1'b0;
    logic [PB:0]   active_rows = '0;
    logic [FB-1:0] num_frames = '0;
    logic          load = 1'b0;
    logic [PB-1:0] load_ptr = '0;
    logic [PB-1:0] row_ptr;
    logic          busy, row_first, row_last, wrap, done;
    logic [FB-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_run = 0;
    int m_l = NR;
    bit m_dir = 0;
    int m_nf = 0;
    int m_ptr = 0;
    int m_fc = 0;
    bit m_wrap = 0;
    bit m_done = 0;

    row_ptr_sequencer #(
        .NUM_ROWS  (NR),
        .FRAME_BITS(FB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .advance    (advance),
        .dir        (dir),
        .active_rows(active_rows),
        .num_frames (num_frames),
        .load       (load),
        .load_ptr   (load_ptr),
        .row_ptr    (row_ptr),
        .busy       (busy),
        .row_first  (row_first),
        .row_last   (row_last),
        .wrap       (wrap),
        .done       (done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int n;
        m_wrap = 0;
        m_done = 0;
        if (!reset_n) begin
            m_run = 0; m_ptr = 0; m_fc = 0; m_l = NR; m_dir = 0;
        end else if (!m_run) begin
            if (start) begin
                m_l   = (int'(active_rows) >= 1 && int'(active_rows) <= NR) ? int'(active_rows) : NR;
                m_dir = dir;
                m_nf  = int'(num_frames);
                m_fc  = 0;
                m_ptr = dir ? m_l - 1 : 0;
                m_run = 1;
            end
        end else if (stop) begin
            m_run = 0; m_done = 1; m_ptr = 0;
        end else if (load) begin
            m_ptr = (int'(load_ptr) >= m_l) ? m_l - 1 : int'(load_ptr);
        end else if (advance) begin
            n = m_ptr + (m_dir ? -1 : 1);
            if (n < 0 || n >= m_l) begin
                m_wrap = 1;
                n = (n + m_l) % m_l;
                m_fc = (m_fc + 1) % (1 << FB);
                if (m_nf != 0 && m_fc == m_nf) begin
                    m_run = 0; m_done = 1; n = 0;
                end
            end
            m_ptr = n;
        end
    endtask

    task automatic cycle(input string tag);
        int first_row;
        @(posedge clk);
        model_step();
        #1;
        first_row = m_dir ? m_l - 1 : 0;
        chk({tag, ".row_ptr"}, row_ptr, m_ptr);
        chk({tag, ".busy"}, busy, m_run);
        chk({tag, ".wrap"}, wrap, m_wrap);
        chk({tag, ".done"}, done, m_done);
        chk({tag, ".frame_cnt"}, frame_cnt, m_fc);
        chk({tag, ".row_first"}, row_first, m_run && m_ptr == first_row);
        chk({tag, ".row_last"}, row_last, m_run && m_ptr == (m_l - 1 - first_row));
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; advance = 0; load = 0;
    endtask

    initial begin
        // Reset state
        reset_n = 0;
        cycle("reset");
        cycle("reset");
        chk("reset_busy", busy, 0);
        reset_n = 1;
        load = 1; stop = 1; advance = 1; load_ptr = 3;
        cycle("idle_ignore");
        chk("idle_ptr", row_ptr, 0);
        idle_inputs();

        // Two full up-frames then auto-complete
        start = 1; active_rows = 6; num_frames = 2; dir = 0;
        cycle("up2");
        start = 0; advance = 1;
        for (int i = 0; i < 12; i++) cycle("up2");
        chk("up2_done", done, 1);
        chk("up2_frames", frame_cnt, 2);
        chk("up2_busy", busy, 0);
        idle_inputs();
        cycle("up2_after");

        // Continuous down-count with out-of-range row count, frame counter roll-over
        start = 1; active_rows = 0; num_frames = 0; dir = 1;
        cycle("down");
        chk("down_first", row_ptr, 5);
        start = 0; dir = 0; advance = 1;
        for (int i = 0; i < 16 * 6; i++) cycle("down");
        chk("down_roll", frame_cnt, 0);
        chk("down_busy", busy, 1);
        chk("down_ptr", row_ptr, 5);
        advance = 0; stop = 1;
        cycle("down_stop");
        chk("down_stop_done", done, 1);
        idle_inputs();

        // Four rows with advance toggling
        start = 1; active_rows = 4; num_frames = 0; dir = 0;
        cycle("toggle");
        start = 0;
        for (int i = 0; i < 10; i++) begin
            advance = (i % 2 == 0);
            cycle("toggle");
        end
        chk("toggle_ptr", row_ptr, 1);
        advance = 0; stop = 1;
        cycle("toggle_stop");
        idle_inputs();

        // Load clamp beats advance; stop beats load
        start = 1; active_rows = 4; num_frames = 0; dir = 0;
        cycle("load");
        start = 0; advance = 1;
        cycle("load");
        cycle("load");
        chk("load_pre", row_ptr, 2);
        load = 1; load_ptr = 7;
        cycle("load");
        chk("load_clamp", row_ptr, 3);
        chk("load_nowrap", wrap, 0);
        stop = 1; load_ptr = 1;
        cycle("stop_load");
        chk("stop_load_ptr", row_ptr, 0);
        chk("stop_load_done", done, 1);
        idle_inputs();

        // Reset mid-run
        start = 1; active_rows = 6; num_frames = 0; dir = 0;
        cycle("rst_mid");
        start = 0; advance = 1;
        for (int i = 0; i < 10; i++) cycle("rst_mid");
        chk("rst_mid_pre_ptr", row_ptr, 4);
        chk("rst_mid_pre_fc", frame_cnt, 1);
        reset_n = 0;
        cycle("rst_mid");
        chk("rst_mid_done", done, 0);
        chk("rst_mid_busy", busy, 0);
        reset_n = 1; advance = 0; start = 1;
        cycle("rst_restart");
        chk("rst_restart_ptr", row_ptr, 0);
        start = 0; advance = 1;
        cycle("rst_restart");
        stop = 1; advance = 0;
        cycle("rst_restart");
        idle_inputs();

        // Single-row frames
        start = 1; active_rows = 1; num_frames = 3; dir = 0;
        cycle("one_row");
        start = 0; advance = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("one_row");
            chk("one_row_wrap", wrap, 1);
            chk("one_row_ptr", row_ptr, 0);
        end
        chk("one_row_done", done, 1);
        chk("one_row_fc", frame_cnt, 3);
        idle_inputs();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n     = ($urandom_range(0, 199) != 0);
            start       = ($urandom_range(0, 7) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            advance     = ($urandom_range(0, 2) != 0);
            load        = ($urandom_range(0, 19) == 0);
            dir         = 1'($urandom_range(0, 1));
            active_rows = (PB + 1)'($urandom_range(0, 7));
            num_frames  = FB'($urandom_range(0, 3));
            load_ptr    = PB'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
